// File: rtl/bug_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : bug_ctl
//  Purpose  : Bug sprite motion and catch-game controller. Bounces the bug
//             once per frame and scores left-clicks landing on the sprite.
//  Revision : 1.0 - initial release
// ============================================================================
module bug_ctl #(
    parameter int          SCREEN_W    = 800,
    parameter int          SCREEN_H    = 600,
    parameter int          BUG_W       = 32,
    parameter int          BUG_H       = 32,
    parameter int          STEP_X      = 2,
    parameter int          STEP_Y      = 1,
    parameter int          X_INIT      = 384,
    parameter int          Y_INIT      = 284,
    parameter int          HOLD_FRAMES = 30,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic        vsync_in,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    input  logic        mouse_left,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        caught,
    output logic [7:0]  score
);

    localparam logic [12:0] c_XMAX     = 13'(SCREEN_W - BUG_W);
    localparam logic [12:0] c_YMAX     = 13'(SCREEN_H - BUG_H);
    localparam logic [12:0] c_STEP_X   = 13'(STEP_X);
    localparam logic [12:0] c_STEP_Y   = 13'(STEP_Y);
    localparam logic [12:0] c_BUG_WM1  = 13'(BUG_W - 1);
    localparam logic [12:0] c_BUG_HM1  = 13'(BUG_H - 1);
    localparam logic [11:0] c_X_INIT   = 12'(X_INIT);
    localparam logic [11:0] c_Y_INIT   = 12'(Y_INIT);
    localparam logic [15:0] c_HOLD     = 16'(HOLD_FRAMES);

    localparam logic [1:0]  c_S_MOVE    = 2'd0;
    localparam logic [1:0]  c_S_CAUGHT  = 2'd1;
    localparam logic [1:0]  c_S_RESPAWN = 2'd2;

    logic [1:0]  r_state;
    logic        r_dir_x;
    logic        r_dir_y;
    logic [15:0] r_hold;
    logic [15:0] r_lfsr;
    logic        r_vsync_d;
    logic        r_tick;
    logic        r_ml_s1;
    logic        r_ml_s2;
    logic        r_ml_d;
    logic        r_click;

    logic [12:0] w_x_sum;
    logic [12:0] w_y_sum;
    logic [11:0] w_xpos_nxt;
    logic [11:0] w_ypos_nxt;
    logic        w_dir_x_nxt;
    logic        w_dir_y_nxt;
    logic        w_hit;
    logic [12:0] w_xr;
    logic [12:0] w_yr;
    logic [11:0] w_x_spawn;
    logic [11:0] w_y_spawn;
    logic        w_lfsr_fb;

    assign w_x_sum = {1'b0, xpos} + c_STEP_X;
    assign w_y_sum = {1'b0, ypos} + c_STEP_Y;

    // One-frame step per axis, clamping to the edge and reversing there.
    always_comb begin
        w_xpos_nxt  = xpos;
        w_dir_x_nxt = r_dir_x;
        if (r_dir_x) begin
            if (w_x_sum <= c_XMAX) begin
                w_xpos_nxt = w_x_sum[11:0];
            end else begin
                w_xpos_nxt  = c_XMAX[11:0];
                w_dir_x_nxt = 1'b0;
            end
        end else if ({1'b0, xpos} >= c_STEP_X) begin
            w_xpos_nxt = xpos - c_STEP_X[11:0];
        end else begin
            w_xpos_nxt  = 12'd0;
            w_dir_x_nxt = 1'b1;
        end
    end

    always_comb begin
        w_ypos_nxt  = ypos;
        w_dir_y_nxt = r_dir_y;
        if (r_dir_y) begin
            if (w_y_sum <= c_YMAX) begin
                w_ypos_nxt = w_y_sum[11:0];
            end else begin
                w_ypos_nxt  = c_YMAX[11:0];
                w_dir_y_nxt = 1'b0;
            end
        end else if ({1'b0, ypos} >= c_STEP_Y) begin
            w_ypos_nxt = ypos - c_STEP_Y[11:0];
        end else begin
            w_ypos_nxt  = 12'd0;
            w_dir_y_nxt = 1'b1;
        end
    end

    assign w_hit = r_click
                && ({1'b0, mouse_xpos} >= {1'b0, xpos})
                && ({1'b0, mouse_xpos} <= ({1'b0, xpos} + c_BUG_WM1))
                && ({1'b0, mouse_ypos} >= {1'b0, ypos})
                && ({1'b0, mouse_ypos} <= ({1'b0, ypos} + c_BUG_HM1));

    // Respawn folds the 10-bit random value back into the legal range.
    assign w_xr      = {3'b000, r_lfsr[9:0]};
    assign w_yr      = {3'b000, r_lfsr[15:6]};
    assign w_x_spawn = (w_xr > c_XMAX) ? 12'(w_xr - c_XMAX) : w_xr[11:0];
    assign w_y_spawn = (w_yr > c_YMAX) ? 12'(w_yr - c_YMAX) : w_yr[11:0];
    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            r_state   <= c_S_MOVE;
            xpos      <= c_X_INIT;
            ypos      <= c_Y_INIT;
            r_dir_x   <= 1'b1;
            r_dir_y   <= 1'b1;
            caught    <= 1'b0;
            score     <= 8'd0;
            r_hold    <= 16'd0;
            r_lfsr    <= LFSR_SEED;
            r_vsync_d <= 1'b0;
            r_tick    <= 1'b0;
            r_ml_s1   <= 1'b0;
            r_ml_s2   <= 1'b0;
            r_ml_d    <= 1'b0;
            r_click   <= 1'b0;
        end else begin
            r_vsync_d <= vsync_in;
            r_tick    <= vsync_in & ~r_vsync_d;
            r_ml_s1   <= mouse_left;
            r_ml_s2   <= r_ml_s1;
            r_ml_d    <= r_ml_s2;
            r_click   <= r_ml_s2 & ~r_ml_d;
            r_lfsr    <= {r_lfsr[14:0], w_lfsr_fb};
            caught    <= 1'b0;

            case (r_state)
                c_S_MOVE: begin
                    // A catch takes priority over a coincident frame step.
                    if (w_hit) begin
                        caught  <= 1'b1;
                        if (score != 8'hFF) begin
                            score <= score + 8'd1;
                        end
                        r_hold  <= c_HOLD;
                        r_state <= c_S_CAUGHT;
                    end else if (r_tick) begin
                        xpos    <= w_xpos_nxt;
                        ypos    <= w_ypos_nxt;
                        r_dir_x <= w_dir_x_nxt;
                        r_dir_y <= w_dir_y_nxt;
                    end
                end
                c_S_CAUGHT: begin
                    // A zero hold count is treated like one frame.
                    if (r_tick) begin
                        if (r_hold <= 16'd1) begin
                            r_state <= c_S_RESPAWN;
                        end else begin
                            r_hold <= r_hold - 16'd1;
                        end
                    end
                end
                c_S_RESPAWN: begin
                    xpos    <= w_x_spawn;
                    ypos    <= w_y_spawn;
                    r_dir_x <= r_lfsr[0];
                    r_dir_y <= r_lfsr[1];
                    r_state <= c_S_MOVE;
                end
                default: begin
                    r_state <= c_S_MOVE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
